ccip_pipe_skid: RTL and testbench

- Parametrised successor to the single-stage CCI-P interface register.
- Inserts RX_STAGES of Rx retiming and TX_STAGES of Tx retiming between the FIU/PR boundary and the AFU.
- Tx path has a skid FIFO so that almost-full back-pressure stays correct despite the added loop latency.
- One instance per Tx channel (c0/c1/c2). Payload is a flat vector, so the block is struct-agnostic.

---
 rtl/ccip_pipe_pkg.sv | 22 ++
 rtl/ccip_pipe_skid_fifo.sv | 58 +++++
 rtl/ccip_pipe_skid.sv | 153 +++++++++++++++
 tb/tb_ccip_pipe_skid.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ccip_pipe_pkg.sv
// Shared limits and elaboration helpers for the CCI-P retiming/skid block.
package ccip_pipe_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MIN_SLACK  = 1;

  // Occupancy at which almost-full must be raised so that AFU_SLACK late beats
  // plus everything still in the Tx pipeline fit in the skid FIFO.
  function automatic int calc_thresh(input int depth, input int slack, input int stages);
    return depth - slack - stages - 1;
  endfunction

  function automatic bit params_legal(input int depth, input int slack,
                                      input int rx_stages, input int tx_stages);
    params_legal = (rx_stages >= 1) && (rx_stages <= MAX_STAGES) &&
                   (tx_stages >= 1) && (tx_stages <= MAX_STAGES) &&
                   (slack >= MIN_SLACK) && (depth > 0) &&
                   ((depth & (depth - 1)) == 0) &&
                   (depth > slack + tx_stages + 1);
  endfunction

endpackage

// File: rtl/ccip_pipe_skid_fifo.sv
// Register-based skid FIFO with first-word-fall-through head and sticky overflow.
module ccip_pipe_skid_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          do_pop, do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ccip_pipe_skid.sv
// Parametrised CCI-P Rx/Tx retiming with a Tx skid FIFO for almost-full slack.
// Define CCIP_PIPE_SKID_STATS_EN to add FIFO high-water-mark and stall counters.
module ccip_pipe_skid
  import ccip_pipe_pkg::*;
#(
  parameter int RX_W       = 64,
  parameter int TX_W       = 64,
  parameter int RX_STAGES  = 2,
  parameter int TX_STAGES  = 2,
  parameter int SKID_DEPTH = 16,
  parameter int AFU_SLACK  = 8
) (
  input  logic            pClk,
  input  logic            pck_cp2af_softReset_n,
  input  logic            rx_in_valid,
  input  logic [RX_W-1:0] rx_in_data,
  output logic            rx_out_valid,
  output logic [RX_W-1:0] rx_out_data,
  input  logic            tx_in_valid,
  input  logic [TX_W-1:0] tx_in_data,
  output logic            tx_almFull_out,
  output logic            tx_out_valid,
  output logic [TX_W-1:0] tx_out_data,
  input  logic            tx_almFull_in,
  output logic            tx_overflow
`ifdef CCIP_PIPE_SKID_STATS_EN
  ,
  output logic [$clog2(SKID_DEPTH):0] stat_hwm,
  output logic [31:0]                 stat_stall_cycles
`endif
);

  localparam int CW     = $clog2(SKID_DEPTH) + 1;
  localparam int OW     = $clog2(SKID_DEPTH + MAX_STAGES + 1);
  localparam int THRESH = calc_thresh(SKID_DEPTH, AFU_SLACK, TX_STAGES);

  if (!params_legal(SKID_DEPTH, AFU_SLACK, RX_STAGES, TX_STAGES)) begin : g_param_err
    $fatal(1, "ccip_pipe_skid: illegal SKID_DEPTH/AFU_SLACK/stage parameters");
  end

  // Valid-only interfaces: a beat transfers on every cycle its valid is high;
  // flow control is the almost-full hint, never a ready.
  logic [RX_STAGES:0] rx_v;
  logic [RX_W-1:0]    rx_d [RX_STAGES+1];
  logic [TX_STAGES:0] tx_v;
  logic [TX_W-1:0]    tx_d [TX_STAGES+1];

  assign rx_v[0] = rx_in_valid;
  assign rx_d[0] = rx_in_data;
  assign tx_v[0] = tx_in_valid;
  assign tx_d[0] = tx_in_data;

  for (genvar s = 0; s < RX_STAGES; s++) begin : g_rx
    logic            v_q;
    logic [RX_W-1:0] d_q;
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) v_q <= 1'b0;
      else                        v_q <= rx_v[s];
    end
    always_ff @(posedge pClk) d_q <= rx_d[s];
    assign rx_v[s+1] = v_q;
    assign rx_d[s+1] = d_q;
  end

  for (genvar s = 0; s < TX_STAGES; s++) begin : g_tx
    logic            v_q;
    logic [TX_W-1:0] d_q;
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) v_q <= 1'b0;
      else                        v_q <= tx_v[s];
    end
    always_ff @(posedge pClk) d_q <= tx_d[s];
    assign tx_v[s+1] = v_q;
    assign tx_d[s+1] = d_q;
  end

  assign rx_out_valid = rx_v[RX_STAGES];
  assign rx_out_data  = rx_d[RX_STAGES];

  logic            alm_q;
  logic            out_valid_q;
  logic [TX_W-1:0] out_data_q;
  logic            alm_out_q;
  logic [TX_W-1:0] fifo_head;
  logic            fifo_empty, fifo_full, fifo_pop;
  logic [CW-1:0]   fifo_count;
  logic [OW-1:0]   occ;

  assign fifo_pop = !fifo_empty && !alm_q;

  ccip_pipe_skid_fifo #(
    .W     (TX_W),
    .DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk       (pClk),
    .rst_n     (pck_cp2af_softReset_n),
    .push      (tx_v[TX_STAGES]),
    .push_data (tx_d[TX_STAGES]),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .overflow  (tx_overflow)
  );

  // Beats still in the Tx pipeline are already committed, so they count too.
  always_comb begin
    occ = OW'(fifo_count) + OW'($countones(tx_v[TX_STAGES:1]));
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      alm_q       <= 1'b1;
      out_valid_q <= 1'b0;
      alm_out_q   <= 1'b1;
    end else begin
      alm_q       <= tx_almFull_in;
      out_valid_q <= fifo_pop;
      alm_out_q   <= (occ >= OW'(THRESH));
    end
  end

  always_ff @(posedge pClk) begin
    if (fifo_pop) out_data_q <= fifo_head;
  end

  assign tx_out_valid   = out_valid_q;
  assign tx_out_data    = out_data_q;
  assign tx_almFull_out = alm_out_q;

`ifdef CCIP_PIPE_SKID_STATS_EN
  logic [CW-1:0] hwm_q;
  logic [31:0]   stall_q;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      if (fifo_count > hwm_q) hwm_q <= fifo_count;
      if (!fifo_empty && alm_q && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_hwm          = hwm_q;
  assign stat_stall_cycles = stall_q;
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_ccip_pipe_skid.sv
// Directed self-checking bench for ccip_pipe_skid (default parameters, THRESH=5).
module tb_ccip_pipe_skid;

  logic        pClk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_in_valid = 1'b0;
  logic [63:0] rx_in_data = '0;
  logic        rx_out_valid;
  logic [63:0] rx_out_data;
  logic        tx_in_valid = 1'b0;
  logic [63:0] tx_in_data = '0;
  logic        tx_almFull_out;
  logic        tx_out_valid;
  logic [63:0] tx_out_data;
  logic        tx_almFull_in = 1'b0;
  logic        tx_overflow;
`ifdef CCIP_PIPE_SKID_STATS_EN
  logic [4:0]  stat_hwm;
  logic [31:0] stat_stall_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 pClk = ~pClk;

  ccip_pipe_skid dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rst_n),
    .rx_in_valid           (rx_in_valid),
    .rx_in_data            (rx_in_data),
    .rx_out_valid          (rx_out_valid),
    .rx_out_data           (rx_out_data),
    .tx_in_valid           (tx_in_valid),
    .tx_in_data            (tx_in_data),
    .tx_almFull_out        (tx_almFull_out),
    .tx_out_valid          (tx_out_valid),
    .tx_out_data           (tx_out_data),
    .tx_almFull_in         (tx_almFull_in),
    .tx_overflow           (tx_overflow)
`ifdef CCIP_PIPE_SKID_STATS_EN
    ,
    .stat_hwm              (stat_hwm),
    .stat_stall_cycles     (stat_stall_cycles)
`endif
  );

  task automatic tick;
    @(posedge pClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rx_in_valid   = 1'b0;
    tx_in_valid   = 1'b0;
    tx_almFull_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Expect every queued beat on consecutive cycles, then `extra` idle cycles.
  task automatic drain(input string tag, input int extra);
    int n;
    n = exp_q.size();
    for (int k = 0; k < n + extra; k++) begin
      tick();
      if (k < n) begin
        chk({tag, "_valid"}, tx_out_valid, 1'b1);
        chk({tag, "_data"}, tx_out_data, exp_q.pop_front());
      end else begin
        chk({tag, "_idle"}, tx_out_valid, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_rx_valid", rx_out_valid, 1'b0);
    chk("rst_tx_valid", tx_out_valid, 1'b0);
    chk("rst_almfull", tx_almFull_out, 1'b1);
    chk("rst_overflow", tx_overflow, 1'b0);
    rst_n = 1'b1;
    chk("rel_almfull_hold", tx_almFull_out, 1'b1);
    tick();
    chk("rel_almfull_drop", tx_almFull_out, 1'b0);

    // Tx minimum latency: TX_STAGES+2 = 4 cycles
    for (int i = 0; i < 6; i++) begin
      tx_in_valid = (i == 0);
      tx_in_data  = 64'hA5;
      tick();
      chk("lat_valid", tx_out_valid, (i == 3));
      if (i == 3) chk("lat_data", tx_out_data, 64'hA5);
    end
    tx_in_valid = 1'b0;

    // Rx passthrough: 0x1..0x20, RX_STAGES = 2 cycles later, no gaps
    for (int i = 0; i < 34; i++) begin
      rx_in_valid = (i < 32);
      rx_in_data  = 64'(i + 1);
      tick();
      if (i >= 1 && i <= 32) begin
        chk("rx_valid", rx_out_valid, 1'b1);
        chk("rx_data", rx_out_data, 64'(i));
      end else begin
        chk("rx_idle", rx_out_valid, 1'b0);
      end
    end
    rx_in_valid = 1'b0;

    // Back-pressure: 13 beats (5 to reach THRESH + 8 slack), release at edge 20
    do_reset();
    tx_almFull_in = 1'b1;
    tick();
    tick();
    for (int e = 0; e <= 20; e++) begin
      tx_in_valid   = (e < 13);
      tx_in_data    = 64'(32'h100 + e);
      if (e < 13) exp_q.push_back(64'(32'h100 + e));
      tx_almFull_in = (e < 20);
      tick();
      chk("bp_no_out", tx_out_valid, 1'b0);
      chk("bp_no_ovf", tx_overflow, 1'b0);
      if (e == 4)  chk("bp_alm_below", tx_almFull_out, 1'b0);
      if (e == 5)  chk("bp_alm_rise", tx_almFull_out, 1'b1);
      if (e == 20) chk("bp_alm_held", tx_almFull_out, 1'b1);
    end
    drain("bp_drain", 3);
    chk("bp_alm_clear", tx_almFull_out, 1'b0);
    chk("bp_no_ovf_end", tx_overflow, 1'b0);
`ifdef CCIP_PIPE_SKID_STATS_EN
    chk("stat_hwm", stat_hwm, 5'd13);
    chk("stat_stall", stat_stall_cycles, 32'd18);
`endif

    // Overflow: 20 beats into 16 entries, AFU ignores almost-full
    do_reset();
    tx_almFull_in = 1'b1;
    tick();
    tick();
    for (int e = 0; e <= 26; e++) begin
      tx_in_valid   = (e < 20);
      tx_in_data    = 64'(32'h200 + e);
      if (e < 16) exp_q.push_back(64'(32'h200 + e));
      tx_almFull_in = (e < 26);
      tick();
      chk("ovf_no_out", tx_out_valid, 1'b0);
      if (e == 17) chk("ovf_before", tx_overflow, 1'b0);
      if (e == 18) chk("ovf_set", tx_overflow, 1'b1);
      if (e == 26) chk("ovf_held", tx_overflow, 1'b1);
    end
    drain("ovf_drain", 4);
    chk("ovf_sticky", tx_overflow, 1'b1);

    // Reset mid-stream with beats buffered and Rx in flight
    do_reset();
    tx_almFull_in = 1'b1;
    tick();
    tick();
    for (int e = 0; e <= 8; e++) begin
      tx_in_valid = (e < 6);
      tx_in_data  = 64'(32'h300 + e);
      rx_in_valid = 1'b1;
      rx_in_data  = 64'(32'h400 + e);
      tick();
    end
    tx_in_valid   = 1'b0;
    tx_almFull_in = 1'b0;
    tick();
    tick();
    chk("mid_tx_valid", tx_out_valid, 1'b1);
    chk("mid_tx_data", tx_out_data, 64'h300);
    chk("mid_rx_valid", rx_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    rx_in_valid = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_out_valid, 1'b0);
    chk("mid_rst_rx_valid", rx_out_valid, 1'b0);
    chk("mid_rst_almfull", tx_almFull_out, 1'b1);
    chk("mid_rst_ovf", tx_overflow, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_tx_idle", tx_out_valid, 1'b0);
      chk("post_rst_rx_idle", rx_out_valid, 1'b0);
    end
    chk("post_rst_almfull", tx_almFull_out, 1'b0);
`ifdef CCIP_PIPE_SKID_STATS_EN
    chk("post_rst_hwm", stat_hwm, 5'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
